audio_in_capture: RTL and testbench
===================================

AUDIO_IN_CAPTURE -- requirements
Module: audio_in_capture

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the output sample word.
REQ-002 Parameter: SAMPLE_BITS, default 24, number of codec bits captured per channel; legal range 8..DATA_WIDTH.
REQ-003 CLK  input  1  system clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 BCLK  input  1  codec bit clock, asynchronous to CLK, at most CLK/8.
REQ-006 LRCK  input  1  codec frame clock; low = left channel, high = right channel.
REQ-007 ADCDAT  input  1  codec serial data, MSB first, I2S format with a one-BCLK delay after each LRCK edge.
REQ-008 x  output  DATA_WIDTH  last complete left-channel sample, sign-extended, registered.
REQ-009 audio_ready  output  1  single-CLK pulse marking that x has just been updated.
REQ-010 frame_err  output  1  single-CLK pulse marking that a left half-frame ended before SAMPLE_BITS bits were captured.
REQ-011 The block SHALL have one clock, CLK, and an asynchronous active-low reset, rst.

Function
REQ-012 BCLK, LRCK and ADCDAT SHALL each pass through a 2-flop synchronizer in the CLK domain before use.
REQ-013 A 3rd registered stage SHALL produce rise and fall detect pulses for synchronized BCLK and LRCK, each one CLK wide.
REQ-014 The FSM SHALL have four states: IDLE, SKIP, SHIFT and HOLD.
REQ-015 IDLE: wait for an LRCK fall; on an LRCK fall go to SKIP.
REQ-016 SKIP: the first BCLK rise after the LRCK fall is discarded (I2S delay bit); then go to SHIFT with the bit counter at 0.
REQ-017 SHIFT: on each BCLK rise, shift synchronized ADCDAT into the LSB of the shift register and increment the bit counter.
REQ-018 When the counter reaches SAMPLE_BITS, the FSM SHALL go to HOLD.
REQ-019 On entering HOLD, x SHALL be loaded with the shift register value sign-extended from bit SAMPLE_BITS-1 to DATA_WIDTH.
REQ-020 audio_ready SHALL pulse high for exactly one CLK, in the cycle x first shows the new value.
REQ-021 Latency: x and audio_ready SHALL update exactly 1 CLK after the CLK edge on which the final BCLK rise is detected.
REQ-022 HOLD: remaining BCLK bits in the left half-frame and all right-channel bits SHALL be ignored.
REQ-023 HOLD: the next LRCK fall SHALL go to SKIP; there is no IDLE pass between consecutive frames.
REQ-024 An LRCK rise while in SKIP or SHIFT SHALL pulse frame_err for one CLK, discard the partial sample, leave x unchanged, suppress audio_ready and return to IDLE.
REQ-025 An LRCK fall and a BCLK rise detected in the same CLK SHALL be treated as the LRCK fall only; that BCLK rise is not counted.
REQ-026 An LRCK fall while in SHIFT SHALL restart the frame in SKIP without asserting frame_err.
REQ-027 audio_ready and frame_err SHALL never both be high in the same cycle.
REQ-028 x SHALL hold its value between audio_ready pulses.
REQ-029 The bit counter SHALL be $clog2(SAMPLE_BITS+1) bits wide and SHALL never wrap.

Reset
REQ-030 While rst is low, x SHALL be 0, audio_ready 0, frame_err 0, FSM IDLE, and the shift register, bit counter and all synchronizer flops 0.
REQ-031 Reset assertion SHALL take effect immediately, independent of CLK.
REQ-032 Reset deassertion mid-frame SHALL leave the FSM in IDLE until the next LRCK fall; no partial sample is ever output.

Verification
REQ-033 The bench SHALL cover sign extension: SAMPLE_BITS=24, 32 BCLK per half-frame, left = 0x800001 -> one audio_ready pulse, x = 0xFF800001.
REQ-034 The bench SHALL cover a positive sample: left = 0x3FFFFF, right = 0xFFFFFF -> x = 0x003FFFFF, with right-channel data never appearing on x.
REQ-035 The bench SHALL cover a short frame: LRCK rises after 10 left bits -> one frame_err pulse, no audio_ready, x keeps its prior value, and the next full frame captures correctly.
REQ-036 The bench SHALL cover latency: audio_ready asserts exactly 4 CLK after the 24th data-bit BCLK rise at the pin (2 sync + 1 edge + 1 register).
REQ-037 The bench SHALL cover reset mid-frame: rst low for 3 CLK during bit 12 -> x=0 and no outputs pulse; after release the first complete frame (0x000123) gives x = 0x00000123.
REQ-038 The bench SHALL cover back-to-back frames: 8 consecutive frames with an incrementing left value -> exactly 8 audio_ready pulses with matching x and no frame_err.

Source files
------------

// File: rtl/audio_in_capture.sv
// ============================================================================
// audio_in_capture : I2S left-channel capture into CLK domain, sign-extended
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module audio_in_capture #(
  parameter int DATA_WIDTH  = 32,
  parameter int SAMPLE_BITS = 24
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  BCLK,
  input  logic                  LRCK,
  input  logic                  ADCDAT,
  output logic [DATA_WIDTH-1:0] x,
  output logic                  audio_ready,
  output logic                  frame_err
);

  localparam int            CW       = $clog2(SAMPLE_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SKIP  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [2:0]             bclk_sync_q, bclk_sync_d;
  logic [2:0]             lrck_sync_q, lrck_sync_d;
  logic [1:0]             adc_sync_q,  adc_sync_d;
  logic                   bclk_rise_q, bclk_rise_d;
  logic                   lrck_rise_q, lrck_rise_d;
  logic                   lrck_fall_q, lrck_fall_d;
  logic [1:0]             state_q,     state_d;
  // Holds the first SAMPLE_BITS-1 bits; the final bit joins straight into x.
  logic [SAMPLE_BITS-2:0] shift_q,     shift_d;
  logic [CW-1:0]          cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0]  x_q,         x_d;
  logic                   ready_q,     ready_d;
  logic                   err_q,       err_d;
  logic [SAMPLE_BITS-1:0] shift_next;

  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], BCLK};
    lrck_sync_d = {lrck_sync_q[1:0], LRCK};
    adc_sync_d  = {adc_sync_q[0], ADCDAT};
    bclk_rise_d = bclk_sync_q[1] & ~bclk_sync_q[2];
    lrck_rise_d = lrck_sync_q[1] & ~lrck_sync_q[2];
    lrck_fall_d = ~lrck_sync_q[1] & lrck_sync_q[2];
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      adc_sync_q  <= '0;
      bclk_rise_q <= 1'b0;
      lrck_rise_q <= 1'b0;
      lrck_fall_q <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      adc_sync_q  <= adc_sync_d;
      bclk_rise_q <= bclk_rise_d;
      lrck_rise_q <= lrck_rise_d;
      lrck_fall_q <= lrck_fall_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  // LRCK events take priority over a coincident BCLK rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (lrck_fall_q) state_d = ST_SKIP;
      end
      ST_SKIP: begin
        if (lrck_rise_q)      state_d = ST_IDLE;
        else if (lrck_fall_q) state_d = ST_SKIP;
        else if (bclk_rise_q) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (lrck_rise_q)                            state_d = ST_IDLE;
        else if (lrck_fall_q)                       state_d = ST_SKIP;
        else if (bclk_rise_q && cnt_q == LAST_BIT)  state_d = ST_HOLD;
      end
      default: begin
        if (lrck_fall_q) state_d = ST_SKIP;
      end
    endcase
  end

  always_comb begin
    shift_next = {shift_q, adc_sync_q[1]};
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_SKIP: begin
        if (lrck_rise_q) begin
          err_d = 1'b1;
        end else if (!lrck_fall_q && bclk_rise_q) begin
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        if (lrck_rise_q) begin
          err_d = 1'b1;
        end else if (!lrck_fall_q && bclk_rise_q) begin
          shift_d = shift_next[SAMPLE_BITS-2:0];
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            x_d     = DATA_WIDTH'($signed(shift_next));
            ready_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign x           = x_q;
  assign audio_ready = ready_q;
  assign frame_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_in_capture.sv
// ============================================================================
// tb_audio_in_capture : directed I2S frames with hand-computed expectations
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_audio_in_capture;

  logic        CLK = 1'b0;
  logic        rst;
  logic        BCLK;
  logic        LRCK;
  logic        ADCDAT;
  logic [31:0] x;
  logic        audio_ready;
  logic        frame_err;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int rdy_cnt   = 0;
  int fe_cnt    = 0;
  int both_cnt  = 0;
  int rise_cyc  = 0;
  int ready_cyc = 0;
  logic [31:0] got_x [16];

  audio_in_capture #(.DATA_WIDTH(32), .SAMPLE_BITS(24)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .BCLK       (BCLK),
    .LRCK       (LRCK),
    .ADCDAT     (ADCDAT),
    .x          (x),
    .audio_ready(audio_ready),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (audio_ready) begin
      if (rdy_cnt < 16) got_x[rdy_cnt] = x;
      rdy_cnt   = rdy_cnt + 1;
      ready_cyc = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (audio_ready && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One BCLK period of 8 CLK; LRCK and data change on the BCLK fall.
  task automatic send_slot(input logic lr, input logic d, input bit do_rst, input bit mark);
    LRCK   = lr;
    ADCDAT = d;
    BCLK   = 1'b0;
    @(negedge CLK);
    if (do_rst) begin
      rst = 1'b0;
      #1 check("rst_async_x", x, 32'h0);
    end
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    if (do_rst) rst = 1'b1;
    BCLK = 1'b1;
    if (mark) rise_cyc = cyc;
    repeat (4) @(negedge CLK);
    BCLK = 1'b0;
  endtask

  task automatic send_half(input logic lr, input logic [23:0] w, input int nbits,
                           input int rst_slot, input bit mark24);
    for (int k = 0; k < 32; k++) begin
      logic d;
      d = (k >= 1 && k <= nbits) ? w[24-k] : 1'b0;
      send_slot(lr, d, k == rst_slot, mark24 && k == 24);
    end
  endtask

  task automatic send_frame(input logic [23:0] left, input logic [23:0] right,
                            input int rst_slot, input bit mark24);
    send_half(1'b0, left, 24, rst_slot, mark24);
    send_half(1'b1, right, 24, -1, 1'b0);
  endtask

  task automatic clear_counts();
    rdy_cnt = 0;
    fe_cnt  = 0;
  endtask

  initial begin
    rst    = 1'b0;
    BCLK   = 1'b0;
    LRCK   = 1'b1;
    ADCDAT = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_x", x, 32'h0);
    check("reset_ready", {31'b0, audio_ready}, 32'h0);
    check("reset_err", {31'b0, frame_err}, 32'h0);
    rst = 1'b1;
    repeat (8) @(negedge CLK);

    // Negative sample sign-extends
    clear_counts();
    send_frame(24'h800001, 24'h000000, -1, 1'b0);
    check("neg_ready_cnt", rdy_cnt, 1);
    check("neg_err_cnt", fe_cnt, 0);
    check("neg_x", x, 32'hFF800001);

    // Positive sample; right channel must not leak
    clear_counts();
    send_frame(24'h3FFFFF, 24'hFFFFFF, -1, 1'b0);
    check("pos_ready_cnt", rdy_cnt, 1);
    check("pos_x", x, 32'h003FFFFF);

    // Short frame: LRCK rises after 10 left bits
    clear_counts();
    for (int k = 0; k <= 10; k++) begin
      logic [23:0] w;
      w = 24'h5A5A5A;
      send_slot(1'b0, (k >= 1) ? w[24-k] : 1'b0, 1'b0, 1'b0);
    end
    send_half(1'b1, 24'hFFFFFF, 24, -1, 1'b0);
    check("short_err_cnt", fe_cnt, 1);
    check("short_ready_cnt", rdy_cnt, 0);
    check("short_x_kept", x, 32'h003FFFFF);
    clear_counts();
    send_frame(24'h123456, 24'h000000, -1, 1'b0);
    check("after_short_x", x, 32'h00123456);
    check("after_short_ready_cnt", rdy_cnt, 1);

    // Latency from 24th data-bit BCLK rise at the pin
    clear_counts();
    send_frame(24'h0000AA, 24'h000000, -1, 1'b1);
    check("latency", ready_cyc - rise_cyc, 4);
    check("latency_x", x, 32'h000000AA);

    // Reset during left bit 12
    clear_counts();
    send_frame(24'h800001, 24'h000000, 12, 1'b0);
    check("rst_mid_x", x, 32'h0);
    check("rst_mid_ready_cnt", rdy_cnt, 0);
    check("rst_mid_err_cnt", fe_cnt, 0);
    clear_counts();
    send_frame(24'h000123, 24'h000000, -1, 1'b0);
    check("after_rst_x", x, 32'h00000123);
    check("after_rst_ready_cnt", rdy_cnt, 1);

    // Eight back-to-back frames
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      logic [23:0] v;
      v = 24'h000100 + 24'(i);
      send_frame(v, ~v, -1, 1'b0);
    end
    check("b2b_ready_cnt", rdy_cnt, 8);
    check("b2b_err_cnt", fe_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_x%0d", i), got_x[i], 32'h00000100 + 32'(i));
    end

    check("ready_err_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
